// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default bit timing.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous UART line; resets to the idle level.
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, mid-bit sampling, glitch-rejecting start detect, framing error pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data_i,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             rxd_s;
  logic             rxd_prev;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       data_n;
  logic             valid_n, ferr_n, busy_n;

  uart_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rxd_prev  <= 1'b1;
      data_i    <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      rxd_prev  <= rxd_s;
      data_i    <= data_n;
      rx_valid  <= valid_n;
      frame_err <= ferr_n;
      busy      <= busy_n;
    end
  end

  // Next-state and output decode; counter free-runs except where a phase boundary clears it
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_W'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift;
    data_n    = data_i;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (rxd_prev && !rxd_s) begin
          state_n = START;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          shift_n = {rxd_s, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        // Leaving at mid stop bit leaves half a bit to catch an immediate next start edge
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rxd_s) begin
            data_n  = shift;
            valid_n = 1'b1;
          end else begin
            ferr_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: serial frames in, expected pulses queued and matched by a monitor.
module tb_uart_rx;

  localparam int CLK_HALF = 5;
  localparam int BIT_NOM  = 160;  // 16 clocks of 10 time units

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] data_i;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;
  exp_t       q[$];
  int         vcyc[$];
  logic [7:0] last_good = 8'h00;
  bit         prev_pulse = 1'b0;

  uart_rx #(.CLKS_PER_BIT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .data_i    (data_i),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #CLK_HALF clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    cyc++;
    if (!rst && (rx_valid || frame_err)) begin
      chk("pulse_exclusive", 32'(rx_valid & frame_err), 32'd0);
      chk("pulse_width", 32'(prev_pulse), 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_pulse", 32'(frame_err), 32'(rx_valid));
        chk("unexpected_pulse_any", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_kind", 32'(frame_err), 32'(e.is_err));
        chk("data_i", 32'(data_i), 32'(e.data));
      end
      if (rx_valid) vcyc.push_back(cyc);
    end
    prev_pulse = rx_valid | frame_err;
  end

  // Drive one frame; abort_bit >= 0 pulses reset halfway through that bit position
  task automatic send_raw(input logic [7:0] b, input logic stop, input int p, input int abort_bit);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      if (i == abort_bit) begin
        #(p / 2);
        rst = 1'b1;
        #(4 * CLK_HALF);
        rst = 1'b0;
        rxd = 1'b1;
        return;
      end
      #(p);
    end
  endtask

  // Reference model: a complete frame yields valid+byte, or error with data_i unchanged
  task automatic frame(input logic [7:0] b, input logic stop, input int p);
    exp_t e;
    e.is_err = !stop;
    e.data   = stop ? b : last_good;
    q.push_back(e);
    if (stop) last_good = b;
    send_raw(b, stop, p, -1);
  endtask

  task automatic idle_bits(input int n, input int p);
    rxd = 1'b1;
    #(n * p);
  endtask

  initial begin
    int hi_at, lo_at;
    repeat (3) @(negedge clk);
    chk("rst_data_i", 32'(data_i), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Ideal 0xA5 frame
    frame(8'hA5, 1'b1, BIT_NOM);
    idle_bits(1, BIT_NOM);
    chk("busy_after_frame", 32'(busy), 32'd0);
    chk("a5_drained", 32'(q.size()), 32'd0);

    // Short low glitch: start detect then reject within half a bit
    @(negedge clk);
    rxd = 1'b0;
    hi_at = -1;
    lo_at = -1;
    for (int i = 0; i < 24; i++) begin
      if (i == 4) rxd = 1'b1;
      @(negedge clk);
      if (busy && hi_at < 0) hi_at = i;
      if (!busy && hi_at >= 0 && lo_at < 0) lo_at = i;
    end
    chk("glitch_busy_seen", 32'(hi_at >= 0), 32'd1);
    chk("glitch_busy_cleared", 32'(lo_at >= 0 && (lo_at - hi_at) <= 8), 32'd1);

    // Framing error followed by a held break; next frame only after a fresh falling edge
    @(negedge clk);
    frame(8'h3C, 1'b0, BIT_NOM);
    idle_bits(0, BIT_NOM);
    rxd = 1'b0;
    #(3 * BIT_NOM);
    chk("break_drained", 32'(q.size()), 32'd0);
    idle_bits(1, BIT_NOM);
    frame(8'h5A, 1'b1, BIT_NOM);
    idle_bits(1, BIT_NOM);

    // Back-to-back with no idle: pulses exactly 160 clocks apart
    vcyc.delete();
    frame(8'h00, 1'b1, BIT_NOM);
    frame(8'hFF, 1'b1, BIT_NOM);
    idle_bits(1, BIT_NOM);
    chk("b2b_count", 32'(vcyc.size()), 32'd2);
    if (vcyc.size() == 2) chk("b2b_spacing", 32'(vcyc[1] - vcyc[0]), 32'd160);

    // Reset during data bit 4, then a clean 0x81
    @(negedge clk);
    send_raw(8'hC3, 1'b1, BIT_NOM, 5);
    last_good = 8'h00;
    @(negedge clk);
    chk("abort_data_i", 32'(data_i), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    idle_bits(1, BIT_NOM);
    frame(8'h81, 1'b1, BIT_NOM);
    idle_bits(1, BIT_NOM);

    // Transmitter clock skew on both sides of nominal
    frame(8'h55, 1'b1, 156);
    idle_bits(1, 156);
    frame(8'h55, 1'b1, 166);
    idle_bits(1, 166);

    // Random traffic: skewed periods, occasional bad stop bits, gaps of 0..2 bits
    for (int n = 0; n < 24; n++) begin
      int         p;
      logic [7:0] b;
      logic       stop;
      int         gap;
      p    = 156 + 2 * int'($urandom_range(0, 5));
      b    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      gap  = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      frame(b, stop, p);
      if (gap > 0) idle_bits(gap, p);
    end

    idle_bits(3, BIT_NOM);
    chk("final_drained", 32'(q.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
